vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Pixel-timing generator for the battleship display path; sits directly upstream of the VGA colour driver.
- Produces the HSYNC/VSYNC strobes and the raster position (current_row = x pixel, current_line = y pixel), plus the active-area enable consumed by the colour driver.
- The default geometry is 640x480 @ 60 Hz: the 8x8 grid of 80x60 cells and the mouse overlay are both defined against this raster.
- The pixel rate is derived from clk_in through an internal clock-enable divider, so the whole video path stays on one clock.

Parameters:
- CLK_DIV, 4, clk_in cycles per pixel (100 MHz -> 25 MHz); legal range >= 1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_ACTIVE, 0, asserted level of hsync_out/vsync_out.

Ports:
- clk_in, input, 1, single system clock.
- rst_in, input, 1, synchronous, active-high reset.
- hsync_out, output, 1, horizontal sync (SYNC_ACTIVE level during the sync window).
- vsync_out, output, 1, vertical sync.
- current_row, output, 10, horizontal pixel counter (0..H_TOTAL-1).
- current_line, output, 10, vertical line counter (0..V_TOTAL-1).
- enable, output, 1, high only inside the visible area.
- pixel_tick, output, 1, one-clk_in pulse per pixel period.
- frame_start, output, 1, one-clk_in pulse at the start of each frame.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - tick is asserted when div_cnt == CLK_DIV-1.
  - With CLK_DIV = 1, tick is constantly high.
- Counters (advance only on tick):
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt increments; at V_TOTAL-1 it wraps to 0.
  - Both wraps happen on the same tick at (799,524) -> (0,0).
- Decode, from the counter values:
  - hsync is active for H_ACTIVE+H_FP <= h_cnt <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
  - vsync is active for V_ACTIVE+V_FP <= v_cnt <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
  - enable = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - Sync outputs drive SYNC_ACTIVE when active, otherwise ~SYNC_ACTIVE.
- Output register stage:
  - All outputs are registered.
  - Latency is exactly 1 clk_in after the counter state they describe, so current_row, current_line, enable and both syncs are mutually aligned.
  - current_row and current_line carry the raw counters, including blanking values; the downstream stage must qualify them with enable.
- pixel_tick: registered copy of tick, aligned with the position outputs.
- frame_start:
  - Pulses for 1 clk_in on the cycle where outputs first show (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - It does not pulse on reset exit.
- Reset, with rst_in sampled high on a clk_in edge:
  - Internal state: div_cnt=0, h_cnt=0, v_cnt=0.
  - Outputs: hsync_out=vsync_out=~SYNC_ACTIVE, enable=0, current_row=0, current_line=0, pixel_tick=0, frame_start=0.
  - Reset asserted mid-line or mid-frame aborts immediately; timing restarts from (0,0) with div_cnt=0 on the first cycle after deassertion.
  - The first tick occurs CLK_DIV cycles after deassertion.
- Between ticks, all outputs except pixel_tick and frame_start hold their values.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480 timing constants and H_TOTAL/V_TOTAL;
  - the grid constants shared with the colour driver (cell width 80, cell height 60, grid 8x8);
  - the colour constants.
- One sub-module, pixel_ce_div: parameterised by CLK_DIV, ports clk_in, rst_in, tick.
- Counter, decode and output register logic stays in vga_timing_gen.

Test Plan:
- Reset behaviour: assert rst_in for 3 cycles, then release.
  - During reset: enable=0, hsync_out=vsync_out=1, current_row=current_line=0.
  - After release, the first pixel_tick arrives exactly 4 clk_in later.
- Line timing: run one line.
  - pixel_tick period is 4 clk_in.
  - enable is high for exactly 640 ticks.
  - hsync_out is low for exactly 96 ticks, starting when current_row=656.
  - The line is 800 ticks = 3200 clk_in long.
- Frame timing: run two frames.
  - vsync_out is low on lines 490..491 only.
  - enable is never high for current_line >= 480.
  - frame_start pulses once per 420000 ticks (1,680,000 clk_in), aligned with current_row=0 and current_line=0.
- Wrap-around: at (799,524), the next tick gives (0,0) and frame_start=1 for one clk_in; at (799,100), the next tick gives (0,101).
- Mid-frame reset: assert rst_in at (300,200).
  - The next cycle shows (0,0), enable=0 and inactive syncs.
  - No frame_start is emitted on resume.
- CLK_DIV=1 build: pixel_tick is constantly high after reset, and a line takes 800 clk_in.
- Grid alignment: cell boundaries at current_row=80k and current_line=60k coincide with enable=1 for every k=1..7.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480 raster timing, grid geometry and colour constants
// Contents:
//   default horizontal/vertical timing and derived totals
//   grid geometry shared with the colour driver (8x8 cells of 80x60 pixels)
//   12-bit RGB colour constants
//   in_window() helper for inclusive range decode
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CELL_W       = 80;
    localparam int CELL_H       = 60;
    localparam int GRID_COLS    = 8;
    localparam int GRID_ROWS    = 8;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t COLOR_BLACK  = 12'h000;
    localparam rgb12_t COLOR_WATER  = 12'h04F;
    localparam rgb12_t COLOR_SHIP   = 12'h888;
    localparam rgb12_t COLOR_HIT    = 12'hF00;
    localparam rgb12_t COLOR_MISS   = 12'hFFF;
    localparam rgb12_t COLOR_GRID   = 12'h0F0;
    localparam rgb12_t COLOR_CURSOR = 12'hFF0;

    function automatic logic in_window(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_ce_div.sv
// rtl/pixel_ce_div.sv - clock-enable divider producing one tick every CLK_DIV clk_in cycles
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-high reset, clears the divider count
//   tick    - high on the last cycle of each CLK_DIV-cycle pixel period
module pixel_ce_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick
);

    localparam int            DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // With CLK_DIV = 1 the count is pinned at 0 == LAST, so tick stays high.
    assign tick = (div_cnt_q == LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/position generator with registered, mutually aligned outputs
// Ports:
//   clk_in       - system clock; pixel rate is clk_in / CLK_DIV via clock enable
//   rst_in       - synchronous active-high reset
//   hsync_out    - horizontal sync, SYNC_ACTIVE level inside the sync window
//   vsync_out    - vertical sync, SYNC_ACTIVE level inside the sync window
//   current_row  - raw horizontal counter (x), includes blanking values
//   current_line - raw vertical counter (y), includes blanking values
//   enable       - high only inside the visible area
//   pixel_tick   - one-cycle pulse per pixel period
//   frame_start  - one-cycle pulse on the first output cycle of (0,0) after a frame wrap
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [9:0] current_row,
    output logic [9:0] current_line,
    output logic       enable,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic       tick;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_last, v_last;
    logic       hsync_act, vsync_act, enable_act;
    logic       wrap_q;

    logic       hsync_q, vsync_q, enable_q, pixel_tick_q, frame_start_q;
    logic [9:0] row_q, line_q;

    pixel_ce_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .tick  (tick)
    );

    assign h_last = (h_cnt_q == 10'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == 10'(V_TOTAL - 1));

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    assign hsync_act  = in_window(int'(h_cnt_q), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1);
    assign vsync_act  = in_window(int'(v_cnt_q), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1);
    assign enable_act = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);

    // Outputs register the current counter state, so they trail the counters by
    // one clk_in. The wrap flag adds the matching stage so frame_start lands on
    // the first cycle the outputs show (0,0), never on reset exit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            wrap_q        <= 1'b0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            enable_q      <= 1'b0;
            row_q         <= '0;
            line_q        <= '0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            wrap_q        <= tick && h_last && v_last;
            hsync_q       <= hsync_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q       <= vsync_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            enable_q      <= enable_act;
            row_q         <= h_cnt_q;
            line_q        <= v_cnt_q;
            pixel_tick_q  <= tick;
            frame_start_q <= wrap_q;
        end
    end

    assign hsync_out    = hsync_q;
    assign vsync_out    = vsync_q;
    assign current_row  = row_q;
    assign current_line = line_q;
    assign enable       = enable_q;
    assign pixel_tick   = pixel_tick_q;
    assign frame_start  = frame_start_q;

endmodule
